// File: rtl/prog_loader.sv
// ============================================================================
//  Module      : prog_loader
//  Description : Serial program loader. Frames a UART byte stream into 12-bit
//                words and writes them into the Simplez program memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader #(
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter logic [8:0] BASE_ADDR   = 9'd0,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [8:0]  mem_addr,
   output logic [11:0] mem_wdata,
   output logic        mem_we,
   output logic        busy,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam int                c_TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_TW-1:0]   c_TMO_LAST = c_TW'(TIMEOUT_CYC - 1);

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_CNTH = 3'd1;
   localparam logic [2:0] c_CNTL = 3'd2;
   localparam logic [2:0] c_WHI  = 3'd3;
   localparam logic [2:0] c_WLO  = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [8:0]      addr_q, addr_d;
   logic [11:0]     wdata_q, wdata_d;
   logic            we_q, we_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            pend_q, pend_d;
   logic            plast_q, plast_d;
   logic            wlast_q, wlast_d;
   logic [9:0]      rem_q, rem_d;
   logic [3:0]      hi_q, hi_d;
   logic            cnth_q, cnth_d;
   logic [c_TW-1:0] tmr_q, tmr_d;

   logic w_tmo;
   logic w_sync_ok;

   assign w_tmo     = (state_q != c_IDLE) && !rx_valid && (tmr_q == c_TMO_LAST);
   // A new frame must wait until the previous frame's final write has retired.
   assign w_sync_ok = rx_valid && (rx_data == SYNC_BYTE) && !busy_q && !pend_q && !we_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= c_IDLE;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
         plast_q <= 1'b0;
         wlast_q <= 1'b0;
         rem_q   <= '0;
         hi_q    <= '0;
         cnth_q  <= 1'b0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
         plast_q <= plast_d;
         wlast_q <= wlast_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         cnth_q  <= cnth_d;
         tmr_q   <= tmr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE: if (w_sync_ok) state_d = c_CNTH;
         c_CNTH: if (rx_valid) state_d = (rx_data[7:1] != 7'd0) ? c_IDLE : c_CNTL;
         c_CNTL: if (rx_valid) state_d = c_WHI;
         c_WHI:  if (rx_valid) state_d = (rx_data[7:4] != 4'd0) ? c_IDLE : c_WLO;
         c_WLO:  if (rx_valid) state_d = (rem_q == 10'd1) ? c_IDLE : c_WHI;
         default: state_d = c_IDLE;
      endcase
      if (w_tmo) state_d = c_IDLE;
   end

   always_comb begin
      addr_d  = we_q ? addr_q + 9'd1 : addr_q;
      wdata_d = wdata_q;
      we_d    = pend_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      pend_d  = 1'b0;
      plast_d = plast_q;
      wlast_d = pend_q ? plast_q : wlast_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      cnth_d  = cnth_q;
      tmr_d   = '0;

      // Write pipeline: accept LO -> strobe one cycle -> advance address.
      if (we_q && wlast_q) begin
         busy_d = 1'b0;
         done_d = 1'b1;
      end

      if (state_q != c_IDLE && !rx_valid) tmr_d = tmr_q + 1'b1;

      case (state_q)
         c_IDLE: if (w_sync_ok) begin
            err_d  = 1'b0;
            busy_d = 1'b1;
            addr_d = BASE_ADDR;
         end
         c_CNTH: if (rx_valid) begin
            cnth_d = rx_data[0];
            if (rx_data[7:1] != 7'd0) begin
               err_d  = 1'b1;
               busy_d = 1'b0;
            end
         end
         c_CNTL: if (rx_valid) rem_d = {1'b0, cnth_q, rx_data} + 10'd1;
         c_WHI: if (rx_valid) begin
            hi_d = rx_data[3:0];
            if (rx_data[7:4] != 4'd0) begin
               err_d  = 1'b1;
               busy_d = 1'b0;
            end
         end
         c_WLO: if (rx_valid) begin
            wdata_d = {hi_q, rx_data};
            pend_d  = 1'b1;
            plast_d = (rem_q == 10'd1);
            rem_d   = rem_q - 10'd1;
         end
         default: ;
      endcase

      if (w_tmo) begin
         err_d  = 1'b1;
         busy_d = 1'b0;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = we_q;
   assign busy      = busy_q;
   assign cpu_hold  = busy_q;
   assign done      = done_q;
   assign error     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Scoreboard testbench for prog_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

   localparam int c_TMO = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [8:0]  mem_addr;
   logic [11:0] mem_wdata;
   logic        mem_we;
   logic        busy;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;
   logic [20:0] sb[$];

   prog_loader #(
      .SYNC_BYTE  (8'hA5),
      .BASE_ADDR  (9'd0),
      .TIMEOUT_CYC(c_TMO)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we   (mem_we),
      .busy     (busy),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Memory-side observer: every write strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we) begin
            wr_cnt++;
            if (sb.size() == 0) begin
               check("spurious_write", 1, 0);
            end else begin
               logic [20:0] e;
               e = sb.pop_front();
               check("wr_addr", 32'(mem_addr), 32'(e[20:12]));
               check("wr_data", 32'(mem_wdata), 32'(e[11:0]));
            end
         end
         if (done) done_cnt++;
      end
   end

   task automatic send(input logic [7:0] b, input int gap);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   function automatic logic [11:0] gen(input int i, input int seed);
      return 12'((i * 37 + seed * 101) & 32'hFFF);
   endfunction

   task automatic send_frame(input int n, input int n_send, input int gap, input int seed);
      logic [11:0] w;
      logic [8:0]  nm1;
      nm1 = 9'(n - 1);
      send(8'hA5, gap);
      send({7'd0, nm1[8]}, gap);
      send(nm1[7:0], gap);
      for (int i = 0; i < n_send; i++) begin
         w = gen(i, seed);
         send({4'd0, w[11:8]}, gap);
         sb.push_back({9'(i), w});
         send(w[7:0], gap);
      end
   endtask

   initial begin
      int w0, d0;
      repeat (3) @(negedge clk);
      check("rst_addr",  32'(mem_addr), 0);
      check("rst_wdata", 32'(mem_wdata), 0);
      check("rst_we",    32'(mem_we), 0);
      check("rst_busy",  32'(busy), 0);
      check("rst_hold",  32'(cpu_hold), 0);
      check("rst_done",  32'(done), 0);
      check("rst_error", 32'(error), 0);
      rst = 1'b0;
      @(negedge clk);

      // Non-sync bytes in IDLE are ignored
      send(8'h00, 1); send(8'hFF, 0); send(8'hA4, 2);
      repeat (3) @(negedge clk);
      check("idle_busy",  32'(busy), 0);
      check("idle_error", 32'(error), 0);
      check("idle_wr",    32'(wr_cnt), 0);

      // Two-word frame with gaps and exact write/done timing
      send(8'hA5, 2);
      check("t1_busy", 32'(busy), 1);
      check("t1_hold", 32'(cpu_hold), 1);
      send(8'h00, 2); send(8'h01, 2);
      send(8'h01, 2);
      sb.push_back({9'd0, 12'h123});
      send(8'h23, 2); send(8'h07, 2);
      sb.push_back({9'd1, 12'h7FF});
      send(8'hFF, 2);
      check("t1_we_k", 32'(mem_we), 0);
      @(negedge clk);
      check("t1_we_k1", 32'(mem_we), 1);
      check("t1_busy_k1", 32'(busy), 1);
      @(negedge clk);
      check("t1_done", 32'(done), 1);
      check("t1_busy_end", 32'(busy), 0);
      check("t1_hold_end", 32'(cpu_hold), 0);
      check("t1_addr_end", 32'(mem_addr), 2);
      @(negedge clk);
      check("t1_done_pulse", 32'(done), 0);
      check("t1_done_cnt", 32'(done_cnt), 1);
      check("t1_wr_cnt", 32'(wr_cnt), 2);

      // Full 512-word frame, back-to-back bytes
      w0 = wr_cnt; d0 = done_cnt;
      send_frame(512, 512, 0, 3);
      repeat (5) @(negedge clk);
      check("t2_writes", 32'(wr_cnt - w0), 512);
      check("t2_done",   32'(done_cnt - d0), 1);
      check("t2_addr_wrap", 32'(mem_addr), 0);
      check("t2_sb_empty", 32'(sb.size()), 0);
      check("t2_busy", 32'(busy), 0);

      // Bad HI byte aborts; next sync clears the error
      w0 = wr_cnt; d0 = done_cnt;
      send(8'hA5, 1); send(8'h00, 0); send(8'h00, 0); send(8'h10, 0);
      repeat (3) @(negedge clk);
      check("t3_error", 32'(error), 1);
      check("t3_busy",  32'(busy), 0);
      check("t3_nowr",  32'(wr_cnt - w0), 0);
      send(8'hA5, 1);
      check("t3_err_clr", 32'(error), 0);
      check("t3_busy2", 32'(busy), 1);
      repeat (c_TMO + 2) @(negedge clk);
      check("t3_tmo_err", 32'(error), 1);

      // Timeout boundary: silence of TIMEOUT_CYC cycles aborts
      w0 = wr_cnt; d0 = done_cnt;
      send(8'hA5, 1); send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
      repeat (c_TMO - 1) @(negedge clk);
      check("t4_pre_err",  32'(error), 0);
      check("t4_pre_busy", 32'(busy), 1);
      @(negedge clk);
      check("t4_err",  32'(error), 1);
      check("t4_busy", 32'(busy), 0);
      check("t4_nowr", 32'(wr_cnt - w0), 0);
      check("t4_nodone", 32'(done_cnt - d0), 0);

      // A byte landing exactly on the expiry cycle is accepted
      send(8'hA5, 1); send(8'h00, 0); send(8'h00, 0);
      send(8'h02, c_TMO - 1);
      sb.push_back({9'd0, 12'h2C3});
      send(8'hC3, c_TMO - 1);
      repeat (4) @(negedge clk);
      check("t4_exp_err",  32'(error), 0);
      check("t4_exp_done", 32'(done_cnt - d0), 1);
      check("t4_exp_sb",   32'(sb.size()), 0);

      // Reset mid-frame after 3 of 5 words
      w0 = wr_cnt;
      send_frame(5, 3, 1, 7);
      repeat (4) @(negedge clk);
      check("t5_wr3", 32'(wr_cnt - w0), 3);
      check("t5_busy_pre", 32'(busy), 1);
      #1 rst = 1'b1;
      #1;
      check("t5_addr",  32'(mem_addr), 0);
      check("t5_wdata", 32'(mem_wdata), 0);
      check("t5_we",    32'(mem_we), 0);
      check("t5_busy",  32'(busy), 0);
      check("t5_hold",  32'(cpu_hold), 0);
      check("t5_error", 32'(error), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_nowr", 32'(wr_cnt - w0), 3);
      w0 = wr_cnt; d0 = done_cnt;
      send_frame(2, 2, 0, 9);
      repeat (5) @(negedge clk);
      check("t5_new_wr",   32'(wr_cnt - w0), 2);
      check("t5_new_done", 32'(done_cnt - d0), 1);
      check("t5_sb_empty", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
